// File: rtl/rshf_serial.sv
// Multi-cycle right shifter: one bit position per clock under a start/busy/done handshake.
// Provides SRL/SRA and recovers word indices from byte addresses.
module rshf_serial #(
    parameter int unsigned WIDTH   = 28,
    parameter int unsigned SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   data_in,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic               arith,
    output logic [WIDTH-1:0]   data_out,
    output logic               busy,
    output logic               done
);

    // Counter must be able to hold WIDTH itself (clamped shift amount).
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   work_q, work_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               arith_q, arith_d;
    logic [WIDTH-1:0]   data_out_q, data_out_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [CNT_W-1:0]   eff_cnt;

    always_comb begin
        if ({{(32 - SHAMT_W){1'b0}}, shamt} >= WIDTH) begin
            eff_cnt = CNT_W'(WIDTH);
        end else begin
            eff_cnt = CNT_W'(shamt);
        end
    end

    always_comb begin
        state_d    = state_q;
        work_d     = work_q;
        cnt_d      = cnt_q;
        arith_d    = arith_q;
        data_out_d = data_out_q;

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    work_d  = data_in;
                    arith_d = arith;
                    cnt_d   = eff_cnt;
                    state_d = StShift;
                end else begin
                    state_d = StIdle;
                end
            end
            StShift: begin
                if (cnt_q != '0) begin
                    work_d = {arith_q & work_q[WIDTH-1], work_q[WIDTH-1:1]};
                    cnt_d  = cnt_q - CNT_W'(1);
                end else begin
                    // Result only becomes visible here, so the old value stays readable while busy.
                    data_out_d = work_q;
                    state_d    = StDone;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d == StShift);
        done_d = (state_d == StDone);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            work_q     <= '0;
            cnt_q      <= '0;
            arith_q    <= 1'b0;
            data_out_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            work_q     <= work_d;
            cnt_q      <= cnt_d;
            arith_q    <= arith_d;
            data_out_q <= data_out_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign data_out = data_out_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_rshf_serial.sv
// Self-checking bench for rshf_serial: directed cases plus random operations
// compared against a plain-arithmetic shift model.
module tb_rshf_serial;

    localparam int unsigned W  = 28;
    localparam int unsigned SW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          arith = 1'b0;
    logic [W-1:0]  data_in = '0;
    logic [SW-1:0] shamt = '0;
    logic [W-1:0]  data_out;
    logic          busy;
    logic          done;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] prev_out = '0;

    always #5 clk = ~clk;

    rshf_serial #(
        .WIDTH   (W),
        .SHAMT_W (SW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .data_in  (data_in),
        .shamt    (shamt),
        .arith    (arith),
        .data_out (data_out),
        .busy     (busy),
        .done     (done)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Sign- or zero-extend to 64 bits, then shift by the clamped amount.
    function automatic logic [W-1:0] ref_shift(input logic [W-1:0] d, input int sh,
                                               input logic ar);
        logic [63:0] v;
        int e;
        e = (sh > int'(W)) ? int'(W) : sh;
        v = {{(64 - W){ar & d[W-1]}}, d};
        v = v >> e;
        return v[W-1:0];
    endfunction

    function automatic int eff_of(input int sh);
        return (sh > int'(W)) ? int'(W) : sh;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [W-1:0] d, input int sh, input logic ar);
        data_in = d;
        shamt   = SW'(sh);
        arith   = ar;
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    // n0 = number of cycles already elapsed since the accepting edge (1 right after launch).
    task automatic wait_done(input int n0, input int eff, input logic [W-1:0] exp,
                             input string tag);
        int n;
        n = n0;
        while (!done && n < 200) begin
            check_eq({tag, "_busy"}, {62'd0, busy, done}, 64'd2);
            check_eq({tag, "_hold"}, data_out, prev_out);
            data_in = W'($urandom);
            shamt   = SW'($urandom);
            arith   = 1'($urandom);
            tick();
            n++;
        end
        check_eq({tag, "_lat"}, n, eff + 2);
        check_eq({tag, "_out"}, data_out, exp);
        check_eq({tag, "_nobusy"}, busy, 0);
        prev_out = exp;
    endtask

    task automatic run(input logic [W-1:0] d, input int sh, input logic ar,
                       input logic [W-1:0] exp, input string tag);
        launch(d, sh, ar);
        wait_done(1, eff_of(sh), exp, tag);
    endtask

    task automatic idle_check(input int cycles, input string tag);
        for (int i = 0; i < cycles; i++) begin
            tick();
            check_eq({tag, "_flags"}, {62'd0, busy, done}, 64'd0);
            check_eq({tag, "_out"}, data_out, prev_out);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] d;
        int           sh;
        logic         ar;

        #12;
        check_eq("rst_out", data_out, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        rst = 1'b0;
        tick();

        run(28'h000_1234, 2, 1'b0, 28'h000_048D, "widx");
        run(28'h800_0000, 4, 1'b1, 28'hF80_0000, "sra");
        run(28'h800_0000, 4, 1'b0, 28'h080_0000, "srl");
        run(28'hABC_DEF0, 0, 1'b0, 28'hABC_DEF0, "zero");
        run(28'hFFF_FFFF, 31, 1'b0, 28'h000_0000, "clampl");
        run(28'h800_0001, 31, 1'b1, 28'hFFF_FFFF, "clampa");
        idle_check(2, "idle");

        // Second request during busy must be dropped entirely.
        launch(28'h000_0100, 8, 1'b0);
        tick();
        data_in = 28'h0FF_FFFF;
        shamt   = SW'(1);
        arith   = 1'b0;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        wait_done(3, 8, 28'h000_0001, "prot");
        idle_check(12, "prot_idle");

        // Back-to-back: new start presented during the done cycle.
        run(28'h000_0040, 3, 1'b0, 28'h000_0008, "b2b_a");
        launch(28'h000_0010, 1, 1'b0);
        wait_done(1, 1, 28'h000_0008, "b2b_b");

        // Asynchronous reset in the middle of a shift.
        launch(28'h123_4567, 10, 1'b1);
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        check_eq("mrst_busy", busy, 0);
        check_eq("mrst_done", done, 0);
        check_eq("mrst_out", data_out, 0);
        #3;
        rst = 1'b0;
        prev_out = '0;
        idle_check(20, "mrst_idle");
        run(28'h000_0F00, 4, 1'b0, 28'h000_00F0, "fresh");

        for (int k = 0; k < 40; k++) begin
            d  = W'($urandom);
            sh = int'($urandom_range(31, 0));
            ar = 1'($urandom);
            launch(d, sh, ar);
            wait_done(1, eff_of(sh), ref_shift(d, sh, ar), "rnd");
            if ($urandom_range(1, 0) == 0) begin
                idle_check(int'($urandom_range(3, 1)), "rnd_idle");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
